// File: rtl/nn_pkg.sv
// Shared neural-network datapath definitions: operand format, layer
// sequencer state encoding and a width helper for address/index buses.
package nn_pkg;

    // Q12.4 signed operands and results
    localparam int DATA_W = 16;
    localparam int FRAC_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } layer_state_t;

    // Bits needed to index n items, never less than one so that
    // single-entry configurations still get a real (constant-zero) bus.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_controller_if.sv
// Bus bundle between the layer sequencer and its surroundings: value and
// weight read ports, MAC operand/clear/accumulator path and the result port.
// master = sequencer side, slave = memories / MAC / result sink side.
interface layer_controller_if #(
    parameter int N_INPUTS = 10,
    parameter int N_NODES  = 4,
    parameter int DATA_W   = nn_pkg::DATA_W
);
    localparam int VA_W  = nn_pkg::width_of(N_INPUTS);
    localparam int WA_W  = nn_pkg::width_of(N_INPUTS * N_NODES);
    localparam int IDX_W = nn_pkg::width_of(N_NODES);

    // memory read ports (data valid one cycle after address)
    logic [VA_W-1:0]   value_addr;
    logic [WA_W-1:0]   weight_addr;
    logic [DATA_W-1:0] value_rdata;
    logic [DATA_W-1:0] weight_rdata;

    // MAC operands, clear and accumulator readback
    logic [DATA_W-1:0] mac_value;
    logic [DATA_W-1:0] mac_weight;
    logic              mac_clear;
    logic [DATA_W-1:0] mac_out;

    // per-node result port
    logic              result_valid;
    logic [IDX_W-1:0]  result_idx;
    logic [DATA_W-1:0] result_data;

    modport master (
        output value_addr, weight_addr,
        input  value_rdata, weight_rdata,
        output mac_value, mac_weight, mac_clear,
        input  mac_out,
        output result_valid, result_idx, result_data
    );

    modport slave (
        input  value_addr, weight_addr,
        output value_rdata, weight_rdata,
        input  mac_value, mac_weight, mac_clear,
        output mac_out,
        input  result_valid, result_idx, result_data
    );

endinterface

// File: rtl/layer_addr_gen.sv
// Input counter, node counter and weight address generation for the layer
// sequencer. The weight address is node_idx*N_INPUTS + cnt, built by
// accumulating N_INPUTS into a per-node base instead of multiplying.
// The value address is the input counter itself, so it holds outside ACCUM.
module layer_addr_gen #(
    parameter int N_INPUTS = 10,
    parameter int N_NODES  = 4,
    parameter int VA_W     = 4,
    parameter int WA_W     = 6,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             node_rst,    // start of a layer pass
    input  logic             node_inc,    // advance to next node
    input  logic             cnt_clr,     // issue address for input 0
    input  logic             cnt_inc,     // issue address for next input
    output logic             cnt_last,
    output logic             node_last,
    output logic [IDX_W-1:0] node_idx,
    output logic [VA_W-1:0]  value_addr,
    output logic [WA_W-1:0]  weight_addr
);

    logic [VA_W-1:0]  cnt_reg;
    logic [IDX_W-1:0] node_idx_reg;
    logic [WA_W-1:0]  weight_base_reg;
    logic [WA_W-1:0]  weight_addr_reg;

    // Node index and weight-row base: cleared per pass, stepped per node.
    always_ff @(posedge clk) begin
        if (reset || node_rst) begin
            node_idx_reg    <= '0;
            weight_base_reg <= '0;
        end else if (node_inc) begin
            node_idx_reg    <= node_idx_reg + IDX_W'(1);
            weight_base_reg <= weight_base_reg + WA_W'(N_INPUTS);
        end
    end

    // Input counter and weight address: restart at the row base, then step
    // together; both hold their last value whenever neither strobe is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg         <= '0;
            weight_addr_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg         <= '0;
            weight_addr_reg <= weight_base_reg;
        end else if (cnt_inc) begin
            cnt_reg         <= cnt_reg + VA_W'(1);
            weight_addr_reg <= weight_addr_reg + WA_W'(1);
        end
    end

    assign cnt_last    = (cnt_reg == VA_W'(N_INPUTS - 1));
    assign node_last   = (node_idx_reg == IDX_W'(N_NODES - 1));
    assign node_idx    = node_idx_reg;
    assign value_addr  = cnt_reg;
    assign weight_addr = weight_addr_reg;

endmodule

// File: rtl/layer_controller.sv
// Fully-connected layer sequencer driving a single MAC. For each node it
// clears the accumulator, streams N_INPUTS value/weight pairs from the
// synchronous-read memories, waits out the MAC latency and emits the
// captured accumulator on the result port.
// Optional build macro: LAYER_CTRL_RELU_EN applies ReLU to captured results.
module layer_controller #(
    parameter int N_INPUTS = 10,
    parameter int N_NODES  = 4,
    parameter int DATA_W   = nn_pkg::DATA_W,
    parameter int MAC_LAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    layer_controller_if.master  bus
);
    import nn_pkg::*;

    localparam int VA_W  = width_of(N_INPUTS);
    localparam int WA_W  = width_of(N_INPUTS * N_NODES);
    localparam int IDX_W = width_of(N_NODES);
    localparam int DR_W  = width_of(MAC_LAT + 1);

    layer_state_t state_reg;
    layer_state_t state_next;

    logic              node_rst;
    logic              node_inc;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_last;
    logic              node_last;
    logic [IDX_W-1:0]  node_idx;
    logic [VA_W-1:0]   value_addr;
    logic [WA_W-1:0]   weight_addr;

    logic              feed_reg;
    logic [DR_W-1:0]   drain_cnt_reg;
    logic              drain_last;
    logic [DATA_W-1:0] result_data_reg;
    logic [DATA_W-1:0] captured;
    logic              mac_clear;
    logic              result_valid;

    layer_addr_gen #(
        .N_INPUTS (N_INPUTS),
        .N_NODES  (N_NODES),
        .VA_W     (VA_W),
        .WA_W     (WA_W),
        .IDX_W    (IDX_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .node_rst    (node_rst),
        .node_inc    (node_inc),
        .cnt_clr     (cnt_clr),
        .cnt_inc     (cnt_inc),
        .cnt_last    (cnt_last),
        .node_last   (node_last),
        .node_idx    (node_idx),
        .value_addr  (value_addr),
        .weight_addr (weight_addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one CLEAR, N_INPUTS ACCUM, 1+MAC_LAT DRAIN, one WRITE per node.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = ACCUM;
            ACCUM:   if (cnt_last) state_next = DRAIN;
            DRAIN:   if (drain_last) state_next = WRITE;
            WRITE:   state_next = node_last ? DONE : CLEAR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs and counter strobes; the MAC is also held clear during reset.
    always_comb begin
        busy         = (state_reg != IDLE);
        done         = (state_reg == DONE);
        mac_clear    = reset || (state_reg == CLEAR);
        result_valid = (state_reg == WRITE);
        node_rst     = (state_reg == IDLE) && start;
        node_inc     = (state_reg == WRITE) && !node_last;
        cnt_clr      = (state_reg == CLEAR);
        cnt_inc      = (state_reg == ACCUM) && !cnt_last;
    end

    // An address presented during ACCUM returns data one cycle later, so
    // feed trails ACCUM by one cycle and covers the first DRAIN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            feed_reg <= 1'b0;
        end else begin
            feed_reg <= (state_reg == ACCUM);
        end
    end

    // Count DRAIN cycles so the last operand has fully propagated through the MAC.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt_reg <= '0;
        end else if (state_reg == DRAIN) begin
            drain_cnt_reg <= drain_cnt_reg + DR_W'(1);
        end else begin
            drain_cnt_reg <= '0;
        end
    end

    assign drain_last = (drain_cnt_reg == DR_W'(MAC_LAT));

`ifdef LAYER_CTRL_RELU_EN
    assign captured = bus.mac_out[DATA_W-1] ? '0 : bus.mac_out;
`else
    assign captured = bus.mac_out;
`endif

    // Capture the finished accumulator on the way into WRITE so it is stable
    // on the result port for the whole result_valid cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_data_reg <= '0;
        end else if ((state_reg == DRAIN) && drain_last) begin
            result_data_reg <= captured;
        end
    end

    assign bus.value_addr   = value_addr;
    assign bus.weight_addr  = weight_addr;
    assign bus.mac_value    = feed_reg ? bus.value_rdata  : '0;
    assign bus.mac_weight   = feed_reg ? bus.weight_rdata : '0;
    assign bus.mac_clear    = mac_clear;
    assign bus.result_valid = result_valid;
    assign bus.result_idx   = node_idx;
    assign bus.result_data  = result_data_reg;

endmodule
